// File: rtl/stall_replay_buffer_if.sv
// Handshake/data bundle between a fixed-latency source, the stall replay
// buffer and the consumer stage.
//   stall     : consumer not accepting this cycle (no request issued)
//   flush     : discard all in-flight and buffered responses
//   in        : source response data, lane c at [c*WIDTH +: WIDTH]
//   issue     : a request is issued this cycle
//   out       : data presented to the consumer
//   out_valid : out carries a tracked response consumed this cycle
//   count     : number of buffered entries (shared by all lanes)
// Modports: slave = the buffer, master = the environment driving it.
interface stall_replay_buffer_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 1,
    parameter int LATENCY  = 1
);
    localparam int COUNT_W = $clog2(LATENCY + 1);

    logic                        stall;
    logic                        flush;
    logic [CHANNELS*WIDTH-1:0]   in;
    logic                        issue;
    logic [CHANNELS*WIDTH-1:0]   out;
    logic                        out_valid;
    logic [COUNT_W-1:0]          count;

    modport master (
        output stall, flush, in,
        input  issue, out, out_valid, count
    );

    modport slave (
        input  stall, flush, in,
        output issue, out, out_valid, count
    );
endinterface

// File: rtl/stall_replay_buffer.sv
// Hold-and-replay buffer between a fixed-latency source that cannot be
// frozen and a consumer stage that may stall. Responses that land while
// the consumer is stalled are captured (up to LATENCY per lane) and
// replayed oldest-first once the stall releases; with nothing buffered the
// source data bypasses straight to the consumer.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : stall_replay_buffer_if.slave (stall, flush, in, issue, out,
//           out_valid, count)
module stall_replay_buffer #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 1,
    parameter int LATENCY  = 1
) (
    input logic                  clk,
    input logic                  reset,
    stall_replay_buffer_if.slave bus
);
    localparam int COUNT_W = $clog2(LATENCY + 1);
    localparam int PTR_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BUS_W   = CHANNELS * WIDTH;

    // trk[i] set: a request issued i+1 cycles ago is still in flight.
    logic [LATENCY-1:0] trk;
    // All lanes share pointers, so each entry holds the full multi-lane word.
    logic [BUS_W-1:0]   mem [LATENCY];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [COUNT_W-1:0] count_q;

    logic arrive;
    logic buffered;
    logic run;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LATENCY - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        arrive   = trk[LATENCY-1];
        buffered = (count_q != '0);
        run      = !reset && !bus.flush;
        // An arrival is buffered when stalled, or when older entries must
        // drain first; with an empty buffer it bypasses instead.
        push     = run && arrive && (bus.stall || buffered);
        pop      = run && !bus.stall && buffered;

        bus.issue     = !bus.stall && !reset;
        bus.out_valid = run && !bus.stall && (buffered || arrive);
        bus.out       = (buffered && !reset) ? mem[rd_ptr] : bus.in;
        bus.count     = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trk <= '0;
        end else if (bus.flush) begin
            // Everything in flight is discarded except a request issued
            // in the flush cycle itself.
            trk <= LATENCY'(bus.issue);
        end else begin
            trk <= (trk << 1) | LATENCY'(bus.issue);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            count_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in;
        end
    end
endmodule

// File: tb/tb_stall_replay_buffer.sv
module tb_stall_replay_buffer;
    localparam int W  = 32;
    localparam int CH = 2;
    localparam int ND = 3;   // DUT g has LATENCY = g+1

    typedef struct {
        int id;
        int icyc;
    } sb_t;

    typedef struct {
        bit rst;
        bit stl;
        bit fl;
        bit e_valid;
        int e_count;
        int e_id;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stl = 1'b0;
    logic fl  = 1'b0;
    logic issue_exp;

    int   cyc     = 0;
    int   next_id = 0;
    bit   chk_en  = 1'b0;
    sb_t  sb[$];
    int   hd [ND] = '{default: 0};
    int   n_cmp   = 0;
    int   n_fail  = 0;
    bit   tab_on  = 1'b0;
    vec_t tab_row;

    logic          issue_a [ND];
    logic          valid_a [ND];
    logic [31:0]   count_a [ND];
    logic [W-1:0]  o0_a [ND];
    logic [W-1:0]  o1_a [ND];
    logic [W-1:0]  i0_a [ND];
    logic [W-1:0]  i1_a [ND];

    always #5 clk = ~clk;

    assign issue_exp = !stl && !rst;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int L = g + 1;
        logic [L-1:0]    src_v  = '0;
        logic [L*32-1:0] src_id = '0;

        stall_replay_buffer_if #(.WIDTH(W), .CHANNELS(CH), .LATENCY(L)) bus ();

        stall_replay_buffer #(.WIDTH(W), .CHANNELS(CH), .LATENCY(L)) dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus)
        );

        // Source model: returns {~id, id} exactly L cycles after issue,
        // regardless of stall, flush or reset.
        always @(posedge clk) begin
            src_v  <= (src_v << 1) | L'(issue_exp);
            src_id <= (src_id << 32) | (L*32)'(next_id);
        end

        assign bus.stall = stl;
        assign bus.flush = fl;
        assign bus.in    = src_v[L-1] ? {~src_id[L*32-1 -: 32], src_id[L*32-1 -: 32]}
                                      : {32'h0BAD_F00D, 32'hDEAD_BEEF};

        assign issue_a[g] = bus.issue;
        assign valid_a[g] = bus.out_valid;
        assign count_a[g] = 32'(bus.count);
        assign o0_a[g]    = bus.out[W-1:0];
        assign o1_a[g]    = bus.out[2*W-1:W];
        assign i0_a[g]    = bus.in[W-1:0];
        assign i1_a[g]    = bus.in[2*W-1:W];
    end

    // Scoreboard push: every issued request, with the cycle it was issued.
    always @(posedge clk) begin
        if (issue_exp) begin
            sb.push_back('{id: next_id, icyc: cyc});
            next_id <= next_id + 1;
        end
        cyc <= cyc + 1;
        if (rst) chk_en <= 1'b1;
    end

    task automatic chk(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s L=%0d cycle=%0d: got %0h, expected %0h",
                     name, d + 1, cyc, act, exp);
        end
    endtask

    // A response is deliverable once cycle >= issue cycle + L; it counts as
    // buffered from the cycle after its arrival until it is consumed.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                int lat;
                int ec;
                int h;
                bit have;
                bit ev;
                logic [63:0] head_tag;
                lat = d + 1;
                h   = hd[d];
                ec  = 0;
                for (int k = h; k < sb.size(); k++) begin
                    if (sb[k].icyc + lat < cyc) ec++;
                end
                have     = (h < sb.size());
                head_tag = have ? {~sb[h].id, sb[h].id} : 64'h0;
                ev       = !rst && !stl && !fl && have && (sb[h].icyc + lat <= cyc);

                chk("issue", d, 64'(issue_a[d]), 64'(issue_exp));
                chk("out_valid", d, 64'(valid_a[d]), 64'(ev));
                chk("count", d, 64'(count_a[d]), 64'(ec));
                chk("count_le_latency", d, 64'(count_a[d] <= 32'(lat)), 64'd1);
                if (rst || ec == 0)
                    chk("out_bypass", d, {o1_a[d], o0_a[d]}, {i1_a[d], i0_a[d]});
                else
                    chk("out_head", d, {o1_a[d], o0_a[d]}, head_tag);
                if (ev) begin
                    chk("data", d, {o1_a[d], o0_a[d]}, head_tag);
                    hd[d] = h + 1;
                end
                if (tab_on && d == 1) begin
                    chk("tab_valid", d, 64'(valid_a[d]), 64'(tab_row.e_valid));
                    chk("tab_count", d, 64'(count_a[d]), 64'(tab_row.e_count));
                    if (tab_row.e_valid)
                        chk("tab_data", d, {o1_a[d], o0_a[d]},
                            {~tab_row.e_id, tab_row.e_id});
                end
                if (rst || fl) hd[d] = sb.size();
            end
        end
    end

    task automatic step(input bit r, input bit s, input bit f);
        rst = r;
        stl = s;
        fl  = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Hand-derived cycle vectors for LATENCY=2: {rst, stall, flush,
        // out_valid, count, lane0 id}. Ids count issued requests from 0.
        vec_t vec [33];
        vec = '{
            '{1,0,0, 0,0, 0},  '{0,0,0, 0,0, 0},  '{0,0,0, 0,0, 0},
            '{0,0,0, 1,0, 0},  '{0,0,0, 1,0, 1},
            '{0,1,0, 0,0, 0},  '{0,1,0, 0,1, 0},  '{0,1,0, 0,2, 0},
            '{0,0,0, 1,2, 2},  '{0,0,0, 1,1, 3},  '{0,0,0, 1,0, 4},
            '{0,0,1, 0,0, 0},  '{0,0,0, 0,0, 0},  '{0,0,0, 1,0, 7},
            '{0,1,1, 0,0, 0},  '{0,0,0, 0,0, 0},  '{0,0,0, 0,0, 0},
            '{0,0,0, 1,0,10},
            '{0,1,0, 0,0, 0},  '{0,1,0, 0,1, 0},  '{0,0,1, 0,2, 0},
            '{0,0,0, 0,0, 0},  '{0,0,0, 1,0,13},
            '{0,1,0, 0,0, 0},  '{0,1,0, 0,1, 0},  '{1,0,0, 0,2, 0},
            '{0,0,0, 0,0, 0},  '{0,0,0, 0,0, 0},  '{0,0,0, 1,0,16},
            '{0,1,0, 0,0, 0},  '{0,0,0, 1,1,17},  '{0,0,0, 1,1,18},
            '{0,0,0, 1,0,19}
        };

        rst = 1'b1;
        stl = 1'b0;
        fl  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int r = 0; r < 33; r++) begin
            tab_on  = 1'b1;
            tab_row = vec[r];
            step(vec[r].rst, vec[r].stl, vec[r].fl);
        end
        tab_on = 1'b0;

        // Single-cycle stall pulses every other cycle.
        for (int i = 0; i < 20; i++) begin
            bit s;
            s = (i % 2) == 1;
            step(1'b0, s, 1'b0);
        end

        // Stall 2, release 1, stall 4, then free-run.
        repeat (4) step(1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);

        // Long stall, then flush mid-drain and flush together with stall.
        repeat (6) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b0, 1'b0);

        // Random mix of stall, flush and reset.
        for (int i = 0; i < 400; i++) begin
            bit s;
            bit f;
            bit r;
            s = ($urandom % 3) == 0;
            f = ($urandom % 16) == 0;
            r = ($urandom % 64) == 0;
            step(r, s, f);
        end

        repeat (10) step(1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
